// File: rtl/alu_b_pkg.sv
// Shared definitions for the ALU operand-B stage: source select codes and
// skid-buffer occupancy states.
package alu_b_pkg;

  typedef enum logic [1:0] {
    B_SEL_REG    = 2'b00,
    B_SEL_CONST  = 2'b01,
    B_SEL_SEXT   = 2'b10,
    B_SEL_BRANCH = 2'b11
  } b_sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_e;

endpackage

// File: rtl/operand_b_skid.sv
// Generic 2-entry valid/ready skid buffer. in_ready and out_valid are
// registered, so there is no combinational path from out_ready to in_ready.
module operand_b_skid
  import alu_b_pkg::*;
#(
  parameter int unsigned DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  buf_state_e    state_q;
  logic          ready_q;
  logic          valid_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] skid_q;
  logic          push;
  logic          pop;

  assign push        = in_valid_i && ready_q;
  assign pop         = out_ready_i && valid_q;
  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;

  // ready_q stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_q  <= in_data_i;
            valid_q <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            skid_q  <= in_data_i;
            ready_q <= 1'b0;
            state_q <= FULL;
          end else if (push && pop) begin
            head_q  <= in_data_i;
          end else if (pop) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ONE;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_b_stage.sv
// Registered ALU operand-B selector with sign-extension/branch shift feeding a
// 2-entry skid buffer. Optional zero-extend for sel 10 under ALU_B_ZERO_EXT_EN.
module alu_operand_b_stage
  import alu_b_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16,
  parameter int unsigned CONST_VAL = 4,
  parameter int unsigned SHIFT     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           sel,
  input  logic [WIDTH-1:0]     b,
  input  logic [IMM_WIDTH-1:0] imm,
`ifdef ALU_B_ZERO_EXT_EN
  input  logic                 zext,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     operand,
  output logic [1:0]           out_sel
);

  logic [WIDTH-1:0] sext_imm;
  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] branch_off;
  logic [WIDTH-1:0] sel_operand;
  logic [WIDTH+1:0] payload_in;
  logic [WIDTH+1:0] payload_out;

  assign sext_imm   = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign branch_off = sext_imm << SHIFT;

`ifdef ALU_B_ZERO_EXT_EN
  assign ext_imm = zext ? {{(WIDTH-IMM_WIDTH){1'b0}}, imm} : sext_imm;
`else
  assign ext_imm = sext_imm;
`endif

  always_comb begin
    sel_operand = '0;
    case (sel)
      B_SEL_REG:    sel_operand = b;
      B_SEL_CONST:  sel_operand = WIDTH'(CONST_VAL);
      B_SEL_SEXT:   sel_operand = ext_imm;
      B_SEL_BRANCH: sel_operand = branch_off;
      default:      sel_operand = '0;
    endcase
  end

  assign payload_in = {sel, sel_operand};

  operand_b_skid #(
    .DW(WIDTH + 2)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (payload_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (payload_out)
  );

  assign out_sel = payload_out[WIDTH+1:WIDTH];
  assign operand = payload_out[WIDTH-1:0];

endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Self-checking bench for alu_operand_b_stage: directed selections, backpressure,
// mid-stream reset, then random traffic against a queue-based reference model.
module tb_alu_operand_b_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [31:0] b;
  logic [15:0] imm;
  logic        zext;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand;
  logic [1:0]  out_sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  s;
    logic [31:0] op;
  } ent_t;

  ent_t q[$];

  alu_operand_b_stage #(
    .WIDTH    (32),
    .IMM_WIDTH(16),
    .CONST_VAL(4),
    .SHIFT    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .b        (b),
    .imm      (imm),
`ifdef ALU_B_ZERO_EXT_EN
    .zext     (zext),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .operand  (operand),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the immediate value, then wrap to 32 bits.
  function automatic logic [31:0] ref_op(input logic [1:0] s, input logic [31:0] bb,
                                         input logic [15:0] im, input bit zx);
    longint v;
    case (s)
      2'd0: v = bb;
      2'd1: v = 4;
      default: begin
        v = im;
        if (im > 16'd32767) v = v - 65536;
`ifdef ALU_B_ZERO_EXT_EN
        if (s == 2'd2 && zx) v = im;
`endif
        if (s == 2'd3) v = v * 4;
      end
    endcase
    return v[31:0];
  endfunction

  // Called at a negedge: checks outputs, drives inputs, advances one cycle.
  task automatic step(input bit iv, input bit orr, input logic [1:0] s,
                      input logic [31:0] bb, input logic [15:0] im, input bit zx);
    bit   push;
    bit   pop;
    ent_t e;
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("operand", operand, q[0].op);
      check("out_sel", out_sel, q[0].s);
    end
    in_valid  = iv;
    out_ready = orr;
    sel       = s;
    b         = bb;
    imm       = im;
    zext      = zx;
    push = iv && (q.size() < 2);
    pop  = orr && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      e.s  = s;
      e.op = ref_op(s, bb, im, zx);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 2'd0;
    b         = '0;
    imm       = '0;
    zext      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    step(1, 1, 2'd0, 32'h12345678, 16'h0000, 0);
    check("sel00", operand, 32'h12345678);
    step(1, 1, 2'd1, 32'hDEADBEEF, 16'h1234, 0);
    check("sel01", operand, 32'h00000004);
    step(1, 1, 2'd2, 32'h0, 16'hFFFC, 0);
    check("sel10", operand, 32'hFFFFFFFC);
    step(1, 1, 2'd3, 32'h0, 16'hFFFC, 0);
    check("sel11_neg", operand, 32'hFFFFFFF0);
    step(1, 1, 2'd3, 32'h0, 16'h7FFF, 0);
    check("sel11_pos", operand, 32'h0001FFFC);
    check("sel11_outsel", out_sel, 2'd3);
`ifdef ALU_B_ZERO_EXT_EN
    step(1, 1, 2'd2, 32'h0, 16'h8001, 1);
    check("zext_on", operand, 32'h00008001);
    step(1, 1, 2'd2, 32'h0, 16'h8001, 0);
    check("zext_off", operand, 32'hFFFF8001);
    step(1, 1, 2'd3, 32'h0, 16'h8001, 1);
    check("zext_branch", operand, 32'hFFFE0004);
`endif
    step(0, 1, 2'd0, 32'h0, 16'h0, 0);

    // Backpressure: A and B fill the buffer, C waits upstream.
    step(1, 0, 2'd0, 32'h0000000A, 16'h0, 0);
    step(1, 0, 2'd0, 32'h0000000B, 16'h0, 0);
    step(1, 0, 2'd0, 32'h0000000C, 16'h0, 0);
    check("bp_full_rdy", in_ready, 1'b0);
    check("bp_head", operand, 32'h0000000A);
    step(1, 1, 2'd0, 32'h0000000C, 16'h0, 0);
    check("bp_second", operand, 32'h0000000B);
    step(1, 1, 2'd0, 32'h0000000C, 16'h0, 0);
    step(0, 1, 2'd0, 32'h0, 16'h0, 0);
    step(0, 1, 2'd0, 32'h0, 16'h0, 0);

    // Mid-stream reset with the buffer full.
    step(1, 0, 2'd1, 32'h0, 16'h0, 0);
    step(1, 0, 2'd3, 32'h0, 16'h1234, 0);
    check("pre_rst_rdy", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_operand", operand, 32'h0);
    check("async_rst_outsel", out_sel, 2'd0);
    check("async_rst_rdy", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_rdy", in_ready, 1'b1);
    check("post_rst_operand", operand, 32'h0);

    for (int unsigned i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) > 1),
           2'($urandom_range(0, 3)), $urandom, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int unsigned i = 0; i < 3; i++) begin
      step(0, 1, 2'd0, 32'h0, 16'h0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
